// File: rtl/mac_acc_pipe.sv
// Pipelined multiply-accumulate engine with internal accumulator feedback.
// Three register stages: S1 captures operands and framing, S2 holds the
// extended product, and S3 updates the accumulator and output registers.
// The accumulator can saturate or wrap, and it keeps a sticky overflow flag.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      beat qualifier (no backpressure)
//   a, b          IN_W-bit operands
//   in_clr        beat starts a new accumulation (discards the partial sum)
//   in_last       beat ends the accumulation (the result is emitted)
//   out_valid     one-cycle pulse when out_data/out_ovf carry a new result
//   out_data      ACC_W-bit accumulated result, held until the next result
//   out_ovf       overflow seen in any beat of the emitted accumulation
module mac_acc_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned ACC_W    = 40,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             in_clr,
  input  logic             in_last,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned ProdW = 2 * IN_W;

  if (ACC_W < ProdW) begin : g_acc_w_check
    $error("mac_acc_pipe: ACC_W must be >= 2*IN_W");
  end

  // S1: operand and framing capture
  logic            s1_valid_q, s1_clr_q, s1_last_q;
  logic [IN_W-1:0] s1_a_q, s1_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      // Framing bits only mean something on a valid beat.
      s1_clr_q   <= in_valid & in_clr;
      s1_last_q  <= in_valid & in_last;
      if (in_valid) begin
        s1_a_q <= a;
        s1_b_q <= b;
      end
    end
  end

  // S2: full-width product, extended to accumulator width
  logic [ProdW-1:0] prod;
  logic [ACC_W-1:0] prod_ext;

  always_comb begin
    if (SIGNED) begin
      prod     = ProdW'($signed(s1_a_q)) * ProdW'($signed(s1_b_q));
      prod_ext = ACC_W'($signed(prod));
    end else begin
      prod     = ProdW'(s1_a_q) * ProdW'(s1_b_q);
      prod_ext = ACC_W'(prod);
    end
  end

  logic             s2_valid_q, s2_clr_q, s2_last_q;
  logic [ACC_W-1:0] s2_prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_clr_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_clr_q   <= s1_clr_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod_ext;
      end
    end
  end

  // S3: accumulate, detect overflow, saturate or wrap
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] base, sum, sat_val, result;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_beat, sticky_next;

  always_comb begin
    base     = s2_clr_q ? '0 : acc_q;
    sum_wide = {1'b0, base} + {1'b0, s2_prod_q};
    sum      = sum_wide[ACC_W-1:0];
    if (SIGNED) begin
      ovf_beat = (base[ACC_W-1] == s2_prod_q[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
      // An overflow is always in the direction of the operands' common sign.
      sat_val  = {base[ACC_W-1], {(ACC_W-1){~base[ACC_W-1]}}};
    end else begin
      ovf_beat = sum_wide[ACC_W];
      sat_val  = '1;
    end
    result      = (SATURATE && ovf_beat) ? sat_val : sum;
    sticky_next = (s2_clr_q ? 1'b0 : ovf_q) | ovf_beat;

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (s2_valid_q) begin
      if (s2_last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_ovf_d   = sticky_next;
        // Auto-clear so the next frame starts from zero even without clr.
        acc_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = result;
        ovf_d = sticky_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: four instances with different parameter sets share
// one stimulus stream. An arithmetic reference model (plain integer sums
// with range clamping) predicts every cycle's outputs. A vector table and
// hand-written sequences carry precomputed expectations for the corner cases.
module tb_mac_acc_pipe;

  // Instance k: 0 = 16/40 signed sat, 1 = 16/32 signed sat,
  //             2 = 16/32 signed wrap, 3 = 16/32 unsigned sat
  localparam int PW   [4] = '{40, 32, 32, 32};
  localparam bit PS   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit PSAT [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic        clk, rst_n, in_valid, in_clr, in_last;
  logic [15:0] a, b;
  logic [3:0]  ov, oo;
  logic [39:0] od0;
  logic [31:0] od1, od2, od3;
  logic [3:0][63:0] gd;

  assign gd[0] = 64'(od0);
  assign gd[1] = 64'(od1);
  assign gd[2] = 64'(od2);
  assign gd[3] = 64'(od3);

  mac_acc_pipe #(.IN_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_clr(in_clr),
    .in_last(in_last), .out_valid(ov[0]), .out_data(od0), .out_ovf(oo[0]));
  mac_acc_pipe #(.IN_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_clr(in_clr),
    .in_last(in_last), .out_valid(ov[1]), .out_data(od1), .out_ovf(oo[1]));
  mac_acc_pipe #(.IN_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_clr(in_clr),
    .in_last(in_last), .out_valid(ov[2]), .out_data(od2), .out_ovf(oo[2]));
  mac_acc_pipe #(.IN_W(16), .ACC_W(32), .SIGNED(1'b0), .SATURATE(1'b1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_clr(in_clr),
    .in_last(in_last), .out_valid(ov[3]), .out_data(od3), .out_ovf(oo[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint           due;
    logic [3:0][63:0] data;
    logic [3:0]       ovf;
  } exp_t;

  typedef struct {
    longint           due;
    logic [3:0]       mask;
    logic [3:0][63:0] data;
    logic [3:0]       ovf;
  } dir_t;

  typedef struct {
    bit               v;
    logic [15:0]      a;
    logic [15:0]      b;
    bit               clr;
    bit               last;
    int               gap;
    logic [3:0]       mask;
    logic [3:0][63:0] data;
    logic [3:0]       ovf;
  } vec_t;

  int     nchk = 0;
  int     nerr = 0;
  longint cyc  = 0;

  exp_t   mq[$];
  dir_t   dq[$];
  vec_t   tbl[$];
  longint m_acc [4];
  bit     m_ovf [4];
  logic [3:0][63:0] hold_d;
  logic [3:0]       hold_o;

  task automatic chk(input string name, input int k, input logic gv, input logic [63:0] gdat,
                     input logic go, input logic ev, input logic [63:0] edat, input logic eo);
    nchk++;
    if (gv !== ev || gdat !== edat || go !== eo) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got v=%0b d=%h o=%0b, want v=%0b d=%h o=%0b",
               name, k, cyc, gv, gdat, go, ev, edat, eo);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    dq.delete();
    hold_d = '0;
    hold_o = '0;
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Reference: exact integer sum, then compare against the representable range.
  task automatic model_beat(input logic [15:0] ai, input logic [15:0] bi, input bit clr,
                            input bit last);
    exp_t   e;
    longint p, s, md, mx, mn;
    bit     o, ovn;
    e.due  = cyc + 3;
    e.data = '0;
    e.ovf  = '0;
    for (int k = 0; k < 4; k++) begin
      md = longint'(1) << PW[k];
      p  = PS[k] ? longint'($signed(ai)) * longint'($signed(bi))
                 : longint'(ai) * longint'(bi);
      s  = (clr ? 0 : m_acc[k]) + p;
      mx = PS[k] ? md / 2 - 1 : md - 1;
      mn = PS[k] ? -(md / 2) : 0;
      o  = (s > mx) || (s < mn);
      if (o) begin
        if (PSAT[k]) s = (s > mx) ? mx : mn;
        else begin
          s = s & (md - 1);
          if (PS[k] && s >= md / 2) s = s - md;
        end
      end
      ovn = (clr ? 1'b0 : m_ovf[k]) | o;
      if (last) begin
        e.data[k] = 64'(s & (md - 1));
        e.ovf[k]  = ovn;
        m_acc[k]  = 0;
        m_ovf[k]  = 1'b0;
      end else begin
        m_acc[k] = s;
        m_ovf[k] = ovn;
      end
    end
    if (last) mq.push_back(e);
  endtask

  task automatic check_cycle();
    logic ev;
    ev = (mq.size() > 0) && (mq[0].due == cyc);
    if (ev) begin
      hold_d = mq[0].data;
      hold_o = mq[0].ovf;
      void'(mq.pop_front());
    end
    for (int k = 0; k < 4; k++)
      chk("model", k, ov[k], gd[k], oo[k], ev, hold_d[k], hold_o[k]);
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      for (int k = 0; k < 4; k++)
        if (dq[0].mask[k])
          chk("vector", k, ov[k], gd[k], oo[k], 1'b1, dq[0].data[k], dq[0].ovf[k]);
      void'(dq.pop_front());
    end
  endtask

  // Called just after a falling edge: drive, advance one cycle, check.
  task automatic tick(input bit v, input logic [15:0] ai, input logic [15:0] bi,
                      input bit clr, input bit last);
    in_valid = v;
    a        = ai;
    b        = bi;
    in_clr   = clr;
    in_last  = last;
    if (v) model_beat(ai, bi, clr, last);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic push_dir(input logic [3:0] mask, input logic [3:0][63:0] data,
                          input logic [3:0] ovf);
    dir_t d;
    d.due  = cyc + 3;
    d.mask = mask;
    d.data = data;
    d.ovf  = ovf;
    dq.push_back(d);
  endtask

  // Asynchronous reset: outputs must clear immediately, not at the next edge.
  task automatic do_reset(input int low_cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_clr   = 1'b0;
    in_last  = 1'b0;
    model_reset();
    #1;
    check_cycle();
    for (int i = 0; i < low_cycles; i++) begin
      @(negedge clk);
      cyc++;
      check_cycle();
    end
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit v, input int ai, input int bi, input bit clr,
                              input bit last, input int gap, input logic [3:0] mask,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic [3:0] ovf);
    vec_t r;
    r.v    = v;
    r.a    = 16'(ai);
    r.b    = 16'(bi);
    r.clr  = clr;
    r.last = last;
    r.gap  = gap;
    r.mask = mask;
    r.data = {d3, d2, d1, d0};
    r.ovf  = ovf;
    return r;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_clr   = 1'b0;
    in_last  = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    #1;
    check_cycle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Dot product -5 with no gaps, then the same with bubbles.
    tbl.push_back(mk(1, 3, 4, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 7, -1, 0, 1, 4, 4'hF, 64'hFF_FFFF_FFFB, 64'hFFFF_FFFB,
                     64'hFFFF_FFFB, 64'hB_FFFB, 4'h0));
    tbl.push_back(mk(1, 3, 4, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -2, 5, 0, 0, 2, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 7, -1, 0, 1, 5, 4'hF, 64'hFF_FFFF_FFFB, 64'hFFFF_FFFB,
                     64'hFFFF_FFFB, 64'hB_FFFB, 4'h0));
    // Back-to-back frames; the second has no clr and relies on auto-clear.
    tbl.push_back(mk(1, 2, 3, 1, 1, 0, 4'hF, 6, 6, 6, 6, 4'h0));
    tbl.push_back(mk(1, 4, 4, 0, 1, 3, 4'hF, 16, 16, 16, 16, 4'h0));
    // Four times 2^30: saturate / wrap / fits in 40 bits / unsigned saturate.
    tbl.push_back(mk(1, -32768, -32768, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -32768, -32768, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -32768, -32768, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -32768, -32768, 0, 1, 0, 4'hF, 64'h1_0000_0000, 64'h7FFF_FFFF,
                     64'h0, 64'hFFFF_FFFF, 4'b1110));
    tbl.push_back(mk(1, 1, 1, 1, 1, 3, 4'hF, 1, 1, 1, 1, 4'h0));
    // 0xFFFF squared twice: unsigned carry out vs signed (-1)*(-1).
    tbl.push_back(mk(1, 65535, 65535, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 65535, 65535, 0, 1, 3, 4'hF, 2, 2, 2, 64'hFFFF_FFFF, 4'b1000));
    // Saturate, then an opposite-sign beat pulls back into range; ovf stays sticky.
    tbl.push_back(mk(1, -32768, -32768, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -32768, -32768, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, -32768, -32768, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 32767, -32768, 0, 1, 4, 4'hF, 64'h8000_8000, 64'h4000_7FFF,
                     64'h8000_8000, 64'hFFFF_8000, 4'b0110));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].mask != 4'h0) push_dir(tbl[i].mask, tbl[i].data, tbl[i].ovf);
      tick(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].last);
      idle(tbl[i].gap);
    end

    // Reset mid-frame: the aborted frame must never emit.
    tick(1'b1, 16'd5, 16'd5, 1'b1, 1'b0);
    tick(1'b1, 16'd5, 16'd5, 1'b0, 1'b0);
    do_reset(1);
    push_dir(4'hF, {64'd2, 64'd2, 64'd2, 64'd2}, 4'h0);
    tick(1'b1, 16'd1, 16'd2, 1'b0, 1'b1);
    idle(4);

    // Randomized stream biased toward extreme operands.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ra, rb;
      int          sel;
      if (i == 750) do_reset(2);
      sel = int'($urandom_range(0, 4));
      ra  = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'hFFFF
                                                           : 16'($urandom);
      sel = int'($urandom_range(0, 4));
      rb  = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'hFFFF
                                                           : 16'($urandom);
      tick($urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
